stage_sequencer: RTL

- Multi-cycle control FSM that drives the five datapath stage strobes (s_fe, s_dc, s_ex, s_me, s_wb) consumed by netpath.
- Acts as the initiator side of the stage-strobe interface; netpath is the responder.
- Sequences one instruction at a time through the stages, stalls on memory wait, times out on a hung memory, and counts retired instructions.
- Sits at top level beside netpath; its strobe outputs connect 1:1 to netpath strobe inputs.

---
 rtl/stage_sequencer.sv | 97 +++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer: one-instruction-at-a-time FE/DC/EX/ME/WB strobe sequencer with
// memory-stall timeout and retired counter. Define SKIP_ME_EN to bypass ME for non-memory ops.
module stage_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             halt_req,
  input  logic             mem_wait,
  input  logic             is_mem,
  output logic             s_fe,
  output logic             s_dc,
  output logic             s_ex,
  output logic             s_me,
  output logic             s_wb,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  // A zero timeout still needs a legal (1-bit) counter even though it never counts.
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

`ifdef SKIP_ME_EN
  localparam bit SKIP_ME = 1'b1;
`else
  localparam bit SKIP_ME = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, FE, DC, EX, ME, WB, FAULT} state_t;

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              is_mem_q;
  logic              stall;
  logic              timeout;

  assign stall   = ((state == FE) || (state == ME)) && mem_wait;
  assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (run) next_state = FE;
      FE:      if (!mem_wait) next_state = DC;
               else if (timeout) next_state = FAULT;
      DC:      next_state = EX;
      EX:      next_state = (SKIP_ME && !is_mem_q) ? WB : ME;
      ME:      if (!mem_wait) next_state = WB;
               else if (timeout) next_state = FAULT;
      WB:      next_state = (halt_req || !run) ? IDLE : FE;
      FAULT:   next_state = FAULT;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they always equal a decode of the state register.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      is_mem_q <= 1'b0;
      retired  <= '0;
      s_fe     <= 1'b0;
      s_dc     <= 1'b0;
      s_ex     <= 1'b0;
      s_me     <= 1'b0;
      s_wb     <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state <= next_state;

      if (next_state != state)
        wait_cnt <= '0;
      else if (stall && (MEM_TIMEOUT != 0))
        wait_cnt <= wait_cnt + 1'b1;

      if (state == DC) is_mem_q <= is_mem;
      if (state == WB) retired  <= retired + 1'b1;

      s_fe  <= (next_state == FE);
      s_dc  <= (next_state == DC);
      s_ex  <= (next_state == EX);
      s_me  <= (next_state == ME);
      s_wb  <= (next_state == WB);
      busy  <= (next_state inside {FE, DC, EX, ME, WB});
      fault <= (next_state == FAULT);
    end
  end

endmodule
